// File: rtl/coin_start_seq.sv
// coin_start_seq: turns Start-1 / Start-2 / coin key presses into timed
// coin-then-start pulse sequences on a shared coin line for the arcade core.
//
// Ports:
//   clk_sys    in  system clock
//   reset      in  synchronous, active-high reset
//   start1_in  in  1P start request level
//   start2_in  in  2P start request level
//   coin_in    in  direct coin key level
//   coin_out   out registered coin line
//   start1_out out registered 1P start
//   start2_out out registered 2P start
//   busy       out registered, high while a sequence is running
module coin_start_seq #(
    parameter int COIN_LEN  = 1_800_000,
    parameter int GAP_LEN   = 3_600_000,
    parameter int START_LEN = 1_800_000,
    parameter int CNT_W     = 22
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic start1_in,
    input  logic start2_in,
    input  logic coin_in,
    output logic coin_out,
    output logic start1_out,
    output logic start2_out,
    output logic busy
);

    typedef enum logic [1:0] {IDLE, COIN, GAP, START} state_t;
    typedef enum logic [1:0] {SEL_S1, SEL_S2, SEL_C} sel_t;

    localparam logic [CNT_W-1:0] COIN_LD  = CNT_W'(COIN_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] START_LD = CNT_W'(START_LEN - 1);

    // Request bit order: [0]=start1, [1]=start2, [2]=coin
    state_t           state, state_n;
    sel_t             sel, sel_n;
    logic [1:0]       coins_left, coins_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       in_q, prev, pend, pend_n;
    logic [2:0]       rise, grant, serve;

    always_comb begin
        state_n = state;
        sel_n   = sel;
        coins_n = coins_left;
        cnt_n   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        grant   = 3'b000;
        rise    = in_q & ~prev;

        unique case (state)
            IDLE: begin
                if (pend[0]) begin
                    grant   = 3'b001;
                    sel_n   = SEL_S1;
                    coins_n = 2'd1;
                end else if (pend[1]) begin
                    grant   = 3'b010;
                    sel_n   = SEL_S2;
                    coins_n = 2'd2;
                end else if (pend[2]) begin
                    grant   = 3'b100;
                    sel_n   = SEL_C;
                    coins_n = 2'd1;
                end
                if (|pend) begin
                    state_n = COIN;
                    cnt_n   = COIN_LD;
                end
            end
            COIN: begin
                if (cnt == '0) begin
                    coins_n = coins_left - 2'd1;
                    cnt_n   = GAP_LD;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (coins_left != 2'd0) begin
                        cnt_n   = COIN_LD;
                        state_n = COIN;
                    end else if (sel == SEL_C) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n   = START_LD;
                        state_n = START;
                    end
                end
            end
            START: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A start request is in service for its whole sequence; a coin
        // request only while its pulse is out, so a new coin key press
        // during the gap queues another coin.
        serve[0] = grant[0] | (state != IDLE && sel == SEL_S1);
        serve[1] = grant[1] | (state != IDLE && sel == SEL_S2);
        serve[2] = grant[2] | (state == COIN && sel == SEL_C);
        pend_n   = (pend & ~grant) | (rise & ~serve);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= SEL_S1;
            coins_left <= 2'd0;
            cnt        <= '0;
            // Reset high so a button held through reset never triggers
            in_q       <= 3'b111;
            prev       <= 3'b111;
            pend       <= 3'b000;
            coin_out   <= 1'b0;
            start1_out <= 1'b0;
            start2_out <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            coins_left <= coins_n;
            cnt        <= cnt_n;
            in_q       <= {coin_in, start2_in, start1_in};
            prev       <= in_q;
            pend       <= pend_n;
            coin_out   <= (state_n == COIN);
            start1_out <= (state_n == START) && (sel_n == SEL_S1);
            start2_out <= (state_n == START) && (sel_n == SEL_S2);
            busy       <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_coin_start_seq.sv
// tb_coin_start_seq: directed cycle-by-cycle checks of coin_start_seq
// with short pulse lengths (COIN=4, GAP=3, START=5).
module tb_coin_start_seq;

    typedef int win_t [6];

    logic clk_sys = 1'b0;
    logic reset = 1'b0;
    logic start1_in = 1'b0;
    logic start2_in = 1'b0;
    logic coin_in = 1'b0;
    logic coin_out, start1_out, start2_out, busy;

    int vectors = 0;
    int errs = 0;
    int cyc = 0;

    win_t i1, i2, ic, ec, e1, e2, eb;
    win_t none = '{0, -1, 0, -1, 0, -1};

    coin_start_seq #(
        .COIN_LEN(4),
        .GAP_LEN(3),
        .START_LEN(5),
        .CNT_W(22)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .start1_in(start1_in),
        .start2_in(start2_in),
        .coin_in(coin_in),
        .coin_out(coin_out),
        .start1_out(start1_out),
        .start2_out(start2_out),
        .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic win(int c, win_t w);
        return (c >= w[0] && c <= w[1]) ||
               (c >= w[2] && c <= w[3]) ||
               (c >= w[4] && c <= w[5]);
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(string tag, string sig, logic got, logic exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s %s cyc %0d got %b want %b",
                   tag, sig, cyc, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk(tag, "coin_out", coin_out, win(cyc, ec));
        chk(tag, "start1_out", start1_out, win(cyc, e1));
        chk(tag, "start2_out", start2_out, win(cyc, e2));
        chk(tag, "busy", busy, win(cyc, eb));
    endtask

    // Cycle c = values just after rising edge c; inputs set before
    // edge c are sampled by edge c.
    task automatic run(string tag, int n, int rst_at);
        start1_in = 1'b0;
        start2_in = 1'b0;
        coin_in = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc = 0;
        check_all({tag, "_rst"});
        for (int c = 1; c <= n; c++) begin
            start1_in = win(c, i1);
            start2_in = win(c, i2);
            coin_in = win(c, ic);
            reset = (c == rst_at);
            tick();
            cyc = c;
            check_all(tag);
        end
        reset = 1'b0;
    endtask

    initial begin
        // Start1 held 20 cycles: one sequence only
        i1 = '{10, 29, 0, -1, 0, -1};
        i2 = none;
        ic = none;
        ec = '{12, 15, 0, -1, 0, -1};
        e1 = '{19, 23, 0, -1, 0, -1};
        e2 = none;
        eb = '{12, 23, 0, -1, 0, -1};
        run("s1_hold", 40, -1);

        // Start2 one-cycle pulse: two coins then start2
        i1 = none;
        i2 = '{10, 10, 0, -1, 0, -1};
        ec = '{12, 15, 19, 22, 0, -1};
        e1 = none;
        e2 = '{26, 30, 0, -1, 0, -1};
        eb = '{12, 30, 0, -1, 0, -1};
        run("s2_pulse", 40, -1);

        // Simultaneous start1 and start2: S1 first, one idle cycle, S2
        i1 = '{10, 10, 0, -1, 0, -1};
        i2 = '{10, 10, 0, -1, 0, -1};
        ec = '{12, 15, 25, 28, 32, 35};
        e1 = '{19, 23, 0, -1, 0, -1};
        e2 = '{39, 43, 0, -1, 0, -1};
        eb = '{12, 23, 25, 43, 0, -1};
        run("s1_s2_same", 50, -1);

        // Coin key, then a second press during the gap
        i1 = none;
        i2 = none;
        ic = '{10, 10, 17, 17, 0, -1};
        ec = '{12, 15, 20, 23, 0, -1};
        e1 = none;
        e2 = none;
        eb = '{12, 18, 20, 26, 0, -1};
        run("coin_twice", 35, -1);

        // Reset mid-coin with start1 held; needs release and re-press
        i1 = '{10, 25, 28, 40, 0, -1};
        ic = none;
        ec = '{12, 12, 30, 33, 0, -1};
        e1 = '{37, 41, 0, -1, 0, -1};
        e2 = none;
        eb = '{12, 12, 30, 41, 0, -1};
        run("reset_mid", 45, 13);

        // Start1 re-pressed during its own START phase is ignored
        i1 = '{10, 10, 20, 21, 0, -1};
        ec = '{12, 15, 0, -1, 0, -1};
        e1 = '{19, 23, 0, -1, 0, -1};
        e2 = none;
        eb = '{12, 23, 0, -1, 0, -1};
        run("s1_repress", 35, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
